// File: rtl/imem_refill_arb.sv
// imem_refill_arb: instruction-side line refill engine and Wishbone master.
// Fetches whole cache lines as critical-word-first wrapping bursts and forwards
// the critical word early for fetch restart. Handles bus retry (with backoff and
// a bounded retry count) and error termination, and drives the fetch stall.
// Optional feature macro: IMEM_TLB_PORT_EN adds a single-word ITLB read channel
// that wins arbitration over line refills in IDLE.
// Note: rst_n is an asynchronous, active-high reset despite its name.

module imem_refill_arb #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned RETRY_MAX  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         freeze,
  input  logic                         req_valid,
  input  logic [ADDR_W-1:0]            req_addr,
  output logic                         line_valid,
  output logic [LINE_WORDS*DATA_W-1:0] line_data,
  output logic                         line_err,
  output logic                         word_valid,
  output logic [DATA_W-1:0]            word_data,
  output logic                         stall_out,
`ifdef IMEM_TLB_PORT_EN
  input  logic                         tlb_req,
  input  logic [ADDR_W-1:0]            tlb_addr,
  output logic                         tlb_ack,
  output logic [DATA_W-1:0]            tlb_rdata,
  output logic                         tlb_err,
`endif
  input  logic                         wb_ack_i,
  input  logic                         wb_err_i,
  input  logic                         wb_rty_i,
  input  logic [DATA_W-1:0]            wb_dat_i,
  output logic                         wb_cyc_o,
  output logic                         wb_stb_o,
  output logic                         wb_we_o,
  output logic [ADDR_W-1:0]            wb_adr_o,
  output logic [3:0]                   wb_sel_o,
  output logic [2:0]                   wb_cti_o,
  output logic [2:0]                   wb_bte_o,
  output logic [DATA_W-1:0]            wb_dat_o
);

  localparam int unsigned IDX_W  = $clog2(LINE_WORDS);
  localparam int unsigned BASE_W = ADDR_W - IDX_W - 2;
  localparam int unsigned CNT_W  = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(LINE_WORDS - 1);
  localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(LINE_WORDS - 2);
  localparam logic [CNT_W-1:0] RETRY_LIM  = CNT_W'(RETRY_MAX);

  // Wrapping burst length encoding for the line size.
  localparam logic [2:0] BTE_WRAP = (LINE_WORDS == 4) ? 3'b001 :
                                    (LINE_WORDS == 8) ? 3'b010 : 3'b011;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLine    = 3'd1,
    StBackoff = 3'd2,
    StResp    = 3'd3
`ifdef IMEM_TLB_PORT_EN
    , StSingle = 3'd4
`endif
  } state_e;

  state_e                             state_q;
  logic                               owner_tlb_q;
  logic [BASE_W-1:0]                  base_q;
  logic [IDX_W-1:0]                   start_q;
  logic [IDX_W-1:0]                   beat_q;
  logic [CNT_W-1:0]                   retry_q;
  logic                               err_q;
  logic [LINE_WORDS-1:0][DATA_W-1:0]  line_q;

  logic             err_ev;
  logic             ack_ev;
  logic             rty_ev;
  logic             fail_ev;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] nxt_idx;

  // Terminations only count while a strobe is out; error beats ack beats retry.
  assign err_ev  = wb_stb_o & wb_err_i;
  assign ack_ev  = wb_stb_o & wb_ack_i & ~wb_err_i;
  assign rty_ev  = wb_stb_o & wb_rty_i & ~wb_ack_i & ~wb_err_i;
  assign fail_ev = err_ev | (rty_ev & (retry_q == RETRY_LIM));

  // Index arithmetic wraps naturally because LINE_WORDS is a power of two.
  assign cur_idx = start_q + beat_q;
  assign nxt_idx = cur_idx + 1'b1;

  assign wb_we_o  = 1'b0;
  assign wb_dat_o = '0;

  assign line_data = line_q;

  // Critical word is forwarded straight from the bus in the cycle it is acked.
  assign word_valid = (state_q == StLine) & ack_ev & (beat_q == '0);
  assign word_data  = word_valid ? wb_dat_i : '0;

  assign line_valid = (state_q == StResp) & ~freeze;
  assign line_err   = line_valid & err_q;

  // A pending miss stalls fetch even while the walker owns the bus.
  assign stall_out = ~rst_n & (req_valid | ((state_q != StIdle) & ~owner_tlb_q));

`ifdef IMEM_TLB_PORT_EN
  assign tlb_ack   = (state_q == StSingle) & (ack_ev | fail_ev);
  assign tlb_err   = (state_q == StSingle) & fail_ev;
  assign tlb_rdata = ((state_q == StSingle) & ack_ev) ? wb_dat_i : '0;
`endif

  // Byte offset bits of the miss address carry no information for word fetches.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[1:0];

  // Arbitration, burst sequencing, retry/backoff and line assembly.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= StIdle;
      owner_tlb_q <= 1'b0;
      base_q      <= '0;
      start_q     <= '0;
      beat_q      <= '0;
      retry_q     <= '0;
      err_q       <= 1'b0;
      line_q      <= '0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_adr_o    <= '0;
      wb_sel_o    <= 4'h0;
      wb_cti_o    <= 3'b000;
      wb_bte_o    <= 3'b000;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!freeze) begin
`ifdef IMEM_TLB_PORT_EN
            if (tlb_req) begin
              state_q     <= StSingle;
              owner_tlb_q <= 1'b1;
              retry_q     <= '0;
              wb_cyc_o    <= 1'b1;
              wb_stb_o    <= 1'b1;
              wb_adr_o    <= tlb_addr;
              wb_sel_o    <= 4'hF;
              wb_cti_o    <= CTI_CLASSIC;
              wb_bte_o    <= 3'b000;
            end else if (req_valid) begin
`else
            if (req_valid) begin
`endif
              state_q     <= StLine;
              owner_tlb_q <= 1'b0;
              base_q      <= req_addr[ADDR_W-1:IDX_W+2];
              start_q     <= req_addr[IDX_W+1:2];
              beat_q      <= '0;
              retry_q     <= '0;
              err_q       <= 1'b0;
              wb_cyc_o    <= 1'b1;
              wb_stb_o    <= 1'b1;
              wb_adr_o    <= {req_addr[ADDR_W-1:2], 2'b00};
              wb_sel_o    <= 4'hF;
              wb_cti_o    <= CTI_INCR;
              wb_bte_o    <= BTE_WRAP;
            end
          end
        end

        StLine: begin
          if (fail_ev) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            err_q    <= 1'b1;
            state_q  <= StResp;
          end else if (ack_ev) begin
            line_q[cur_idx] <= wb_dat_i;
            if (beat_q == LAST_IDX) begin
              wb_cyc_o <= 1'b0;
              wb_stb_o <= 1'b0;
              state_q  <= StResp;
            end else begin
              beat_q   <= beat_q + 1'b1;
              wb_adr_o <= {base_q, nxt_idx, 2'b00};
              wb_cti_o <= (beat_q == PENULT_IDX) ? CTI_END : CTI_INCR;
            end
          end else if (rty_ev) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            retry_q  <= retry_q + 1'b1;
            state_q  <= StBackoff;
          end
        end

`ifdef IMEM_TLB_PORT_EN
        StSingle: begin
          if (fail_ev || ack_ev) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            state_q  <= StIdle;
          end else if (rty_ev) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            retry_q  <= retry_q + 1'b1;
            state_q  <= StBackoff;
          end
        end
`endif

        // Address and cti were left at the retried beat, so re-issue is just cyc/stb.
        StBackoff: begin
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
`ifdef IMEM_TLB_PORT_EN
          state_q  <= owner_tlb_q ? StSingle : StLine;
`else
          state_q  <= StLine;
`endif
        end

        StResp: begin
          if (!freeze) begin
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_refill_arb.sv
// Directed self-checking bench for imem_refill_arb (LINE_WORDS=8, RETRY_MAX=4).
// Cycle 0 is the cycle in which a request is presented in IDLE. The bus model
// returns 0xA000_0000 | address as read data.

module tb_imem_refill_arb;

  logic         clk;
  logic         rst_n;
  logic         freeze;
  logic         req_valid;
  logic [31:0]  req_addr;
  logic         line_valid;
  logic [255:0] line_data;
  logic         line_err;
  logic         word_valid;
  logic [31:0]  word_data;
  logic         stall_out;
  logic         wb_ack_i, wb_err_i, wb_rty_i;
  logic [31:0]  wb_dat_i;
  logic         wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0]  wb_adr_o;
  logic [3:0]   wb_sel_o;
  logic [2:0]   wb_cti_o, wb_bte_o;
  logic [31:0]  wb_dat_o;
`ifdef IMEM_TLB_PORT_EN
  logic         tlb_req;
  logic [31:0]  tlb_addr;
  logic         tlb_ack;
  logic [31:0]  tlb_rdata;
  logic         tlb_err;
`endif

  imem_refill_arb #(
    .LINE_WORDS(8),
    .DATA_W    (32),
    .ADDR_W    (32),
    .RETRY_MAX (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .freeze    (freeze),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .line_valid(line_valid),
    .line_data (line_data),
    .line_err  (line_err),
    .word_valid(word_valid),
    .word_data (word_data),
    .stall_out (stall_out),
`ifdef IMEM_TLB_PORT_EN
    .tlb_req   (tlb_req),
    .tlb_addr  (tlb_addr),
    .tlb_ack   (tlb_ack),
    .tlb_rdata (tlb_rdata),
    .tlb_err   (tlb_err),
`endif
    .wb_ack_i  (wb_ack_i),
    .wb_err_i  (wb_err_i),
    .wb_rty_i  (wb_rty_i),
    .wb_dat_i  (wb_dat_i),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_adr_o  (wb_adr_o),
    .wb_sel_o  (wb_sel_o),
    .wb_cti_o  (wb_cti_o),
    .wb_bte_o  (wb_bte_o),
    .wb_dat_o  (wb_dat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-run observation logs.
  int           stb_n;
  logic [31:0]  adr_log [64];
  logic [2:0]   cti_log [64];
  logic [2:0]   bte_log [64];
  logic         cyc_at  [64];
  logic         stb_at  [64];
  logic         stall_at[64];
  int           wv_cyc;
  logic [31:0]  wv_data;
  int           lv_cyc;
  logic         lv_err;
  logic [255:0] lv_data;
  int           tlb_cyc;
  logic [31:0]  tlb_data;
  logic [255:0] exp_line;

  // Issues one line request at cycle 0 and plays the bus slave. Beat number
  // rty_beat is answered with retry rty_cnt times; beat err_beat with error.
  // Entered and left 1 time unit after a rising edge.
  task automatic run_line(input logic [31:0] addr, input int rty_beat, input int rty_cnt,
                          input int err_beat, input int fz_lo, input int fz_hi);
    int beats;
    int rdone;
    int post;
    stb_n = 0; wv_cyc = -1; lv_cyc = -1; tlb_cyc = -1;
    wv_data = '0; lv_err = 1'b0; lv_data = '0; tlb_data = '0;
    for (int i = 0; i < 64; i++) begin
      cyc_at[i] = 1'b0; stb_at[i] = 1'b0; stall_at[i] = 1'b0;
    end
    beats = 0; rdone = 0; post = -1;
    req_addr  = addr;
    req_valid = 1'b1;
    for (int c = 0; c < 64; c++) begin
      freeze   = (c >= fz_lo) && (c <= fz_hi);
      wb_ack_i = 1'b0; wb_rty_i = 1'b0; wb_err_i = 1'b0;
      wb_dat_i = 32'hA000_0000 | wb_adr_o;
      if (wb_stb_o) begin
        if (wb_cti_o == 3'b000) wb_ack_i = 1'b1;
        else if (beats == rty_beat && rdone < rty_cnt) begin
          wb_rty_i = 1'b1;
          rdone++;
        end else if (beats == err_beat) wb_err_i = 1'b1;
        else begin
          wb_ack_i = 1'b1;
          beats++;
        end
      end
      #3;
      cyc_at[c]   = wb_cyc_o;
      stb_at[c]   = wb_stb_o;
      stall_at[c] = stall_out;
      if (wb_stb_o) begin
        adr_log[stb_n] = wb_adr_o;
        cti_log[stb_n] = wb_cti_o;
        bte_log[stb_n] = wb_bte_o;
        stb_n++;
      end
      if (word_valid && wv_cyc < 0) begin
        wv_cyc  = c;
        wv_data = word_data;
      end
`ifdef IMEM_TLB_PORT_EN
      if (tlb_ack) begin
        tlb_cyc  = c;
        tlb_data = tlb_rdata;
        tlb_req  = 1'b0;
      end
`endif
      if (line_valid && lv_cyc < 0) begin
        lv_cyc    = c;
        lv_err    = line_err;
        lv_data   = line_data;
        req_valid = 1'b0;
        post      = c + 1;
      end
      @(posedge clk);
      #1;
      if (c == post) break;
    end
    req_valid = 1'b0; freeze = 1'b0;
    wb_ack_i = 1'b0; wb_rty_i = 1'b0; wb_err_i = 1'b0;
  endtask

  logic [31:0] exp_adr1 [8];
  logic [31:0] exp_adr2 [10];
  int          lv_cnt;
  int          stb_cnt;

  initial begin
    exp_adr1 = '{32'h1014, 32'h1018, 32'h101C, 32'h1000, 32'h1004, 32'h1008, 32'h100C,
                 32'h1010};
    exp_adr2 = '{32'h1014, 32'h1018, 32'h101C, 32'h1000, 32'h1000, 32'h1000, 32'h1004,
                 32'h1008, 32'h100C, 32'h1010};
    for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'hA000_1000 + 32'(4 * i);

    rst_n = 1'b1; freeze = 1'b0; req_valid = 1'b0; req_addr = '0;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = '0;
`ifdef IMEM_TLB_PORT_EN
    tlb_req = 1'b0; tlb_addr = '0;
`endif

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst bus ctl", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o, wb_bte_o}, 0);
    check_eq("rst bus adr/dat", {wb_adr_o, wb_dat_o}, 0);
    check_eq("rst line", {line_valid, line_err, line_data}, 0);
    check_eq("rst word/stall", {word_valid, word_data, stall_out}, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;

    // Zero-wait line refill from word 5.
    run_line(32'h0000_1014, -1, 0, -1, -1, -1);
    check_eq("t1 beats", stb_n, 8);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("t1 adr%0d", i), adr_log[i], exp_adr1[i]);
      check_eq($sformatf("t1 cti%0d", i), cti_log[i], (i < 7) ? 3'b010 : 3'b111);
    end
    check_eq("t1 bte", bte_log[0], 3'b010);
    check_eq("t1 word_valid cyc", wv_cyc, 1);
    check_eq("t1 word_data", wv_data, 32'hA000_1014);
    check_eq("t1 line_valid cyc", lv_cyc, 9);
    check_eq("t1 line_err", lv_err, 1'b0);
    check_eq("t1 line_data", lv_data, exp_line);
    check_eq("t1 stall c9", stall_at[9], 1'b1);
    check_eq("t1 stall c10", stall_at[10], 1'b0);

    // Retry twice on beat 3.
    run_line(32'h0000_1014, 3, 2, -1, -1, -1);
    check_eq("t2 strobes", stb_n, 10);
    for (int i = 0; i < 10; i++) check_eq($sformatf("t2 adr%0d", i), adr_log[i], exp_adr2[i]);
    check_eq("t2 backoff c5", stb_at[5], 1'b0);
    check_eq("t2 backoff c7", stb_at[7], 1'b0);
    check_eq("t2 line_valid cyc", lv_cyc, 13);
    check_eq("t2 line_err", lv_err, 1'b0);
    check_eq("t2 line_data", lv_data, exp_line);

    // Retry on every attempt: exhausted after five attempts.
    run_line(32'h0000_1014, 0, 99, -1, -1, -1);
    check_eq("t3 attempts", stb_n, 5);
    check_eq("t3 attempt adr", adr_log[4], 32'h1014);
    check_eq("t3 line_valid cyc", lv_cyc, 10);
    check_eq("t3 line_err", lv_err, 1'b1);

    // Next request after exhaustion behaves normally.
    run_line(32'h0000_1014, -1, 0, -1, -1, -1);
    check_eq("t3b line_valid cyc", lv_cyc, 9);
    check_eq("t3b line_err", lv_err, 1'b0);
    check_eq("t3b line_data", lv_data, exp_line);

    // Error on beat 2.
    run_line(32'h0000_1014, -1, 0, 2, -1, -1);
    check_eq("t4 beats", stb_n, 3);
    check_eq("t4 cyc c4", cyc_at[4], 1'b0);
    check_eq("t4 line_valid cyc", lv_cyc, 4);
    check_eq("t4 line_err", lv_err, 1'b1);

    // Freeze held across cycles 2..11: bus unaffected, delivery waits.
    run_line(32'h0000_1014, -1, 0, -1, 2, 11);
    check_eq("t5 beats", stb_n, 8);
    check_eq("t5 word_valid cyc", wv_cyc, 1);
    check_eq("t5 line_valid cyc", lv_cyc, 12);
    check_eq("t5 line_data", lv_data, exp_line);

`ifdef IMEM_TLB_PORT_EN
    // TLB and line request together: TLB first, then the line burst.
    tlb_req  = 1'b1;
    tlb_addr = 32'h0000_2000;
    run_line(32'h0000_1014, -1, 0, -1, -1, -1);
    check_eq("t6 tlb adr", adr_log[0], 32'h2000);
    check_eq("t6 tlb cti/bte", {cti_log[0], bte_log[0]}, 6'b000_000);
    check_eq("t6 tlb_ack cyc", tlb_cyc, 1);
    check_eq("t6 tlb_rdata", tlb_data, 32'hA000_2000);
    check_eq("t6 line first adr", adr_log[1], 32'h1014);
    check_eq("t6 line_valid cyc", lv_cyc, 11);
    check_eq("t6 line_data", lv_data, exp_line);
    lv_cnt = 0;
    for (int i = 0; i <= 11; i++) if (stall_at[i]) lv_cnt++;
    check_eq("t6 stall held", lv_cnt, 12);
`endif

    // Asynchronous reset in the middle of a burst.
    req_addr  = 32'h0000_1014;
    req_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      wb_ack_i = wb_stb_o;
      wb_dat_i = 32'hA000_0000 | wb_adr_o;
      @(posedge clk);
      #1;
    end
    wb_ack_i = wb_stb_o;
    wb_dat_i = 32'hA000_0000 | wb_adr_o;
    #1;
    rst_n     = 1'b1;
    wb_ack_i  = 1'b0;
    req_valid = 1'b0;
    #1;
    check_eq("t7 cyc/stb drop", {wb_cyc_o, wb_stb_o}, 2'b00);
    check_eq("t7 bus cleared", {wb_adr_o, wb_sel_o, wb_cti_o, wb_bte_o}, 0);
    check_eq("t7 line cleared", {line_valid, line_err, line_data}, 0);
    check_eq("t7 word/stall", {word_valid, word_data, stall_out}, 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    lv_cnt = 0;
    stb_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      wb_ack_i = wb_stb_o;
      #3;
      if (line_valid) lv_cnt++;
      if (wb_stb_o) stb_cnt++;
      @(posedge clk);
      #1;
    end
    wb_ack_i = 1'b0;
    check_eq("t7 no line_valid", lv_cnt, 0);
    check_eq("t7 no beats", stb_cnt, 0);

    // Recovery after reset.
    run_line(32'h0000_101C, -1, 0, -1, -1, -1);
    check_eq("t8 word_data", wv_data, 32'hA000_101C);
    check_eq("t8 line_valid cyc", lv_cyc, 9);
    check_eq("t8 line_data", lv_data, exp_line);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
